// File: rtl/object_compositor.sv
// object_compositor: per-pixel compositor with NUM_OBJ rectangle/circle objects.
// A 3-stage pipeline (distance, hit test, priority select) produces registered RGB.
// Descriptors are written into a shadow table and copied to the active table on
// frame_start, so the picture never tears mid-frame.
// Ports:
//   Clk, Reset_n                 pixel clock, async active-low reset
//   DrawX, DrawY, blank          current pixel and visible flag
//   frame_start                  commits shadow -> active
//   cfg_valid/cfg_ready + cfg_*  descriptor write port
//   bg_we, bg_color              immediate background colour write
//   Red, Green, Blue, blank_out  pixel output, 3 clocks after input
//   hit_valid, hit_idx           winning object of the output pixel
module object_compositor #(
    parameter int unsigned NUM_OBJ = 8,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 8,
    parameter logic [3*COLOR_W-1:0] BG_COLOR = 24'h70707F
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       blank,
    input  logic                       frame_start,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_OBJ)-1:0] cfg_idx,
    input  logic                       cfg_en,
    input  logic                       cfg_circle,
    input  logic [COORD_W-1:0]         cfg_x,
    input  logic [COORD_W-1:0]         cfg_y,
    input  logic [COORD_W-1:0]         cfg_hw,
    input  logic [COORD_W-1:0]         cfg_hh,
    input  logic [3*COLOR_W-1:0]       cfg_color,
    input  logic                       bg_we,
    input  logic [3*COLOR_W-1:0]       bg_color,
    output logic [COLOR_W-1:0]         Red,
    output logic [COLOR_W-1:0]         Green,
    output logic [COLOR_W-1:0]         Blue,
    output logic                       blank_out,
    output logic                       hit_valid,
    output logic [$clog2(NUM_OBJ)-1:0] hit_idx
);
    localparam int unsigned IDX_W = $clog2(NUM_OBJ);
    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned SQ_W  = 2 * COORD_W + 2;

    typedef struct packed {
        logic               en;
        logic               circle;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] hw;
        logic [COORD_W-1:0] hh;
        logic [RGB_W-1:0]   color;
    } obj_t;

    typedef struct packed {
        logic               en;
        logic               circle;
        logic [COORD_W-1:0] adx;
        logic [COORD_W-1:0] ady;
        logic [COORD_W-1:0] hw;
        logic [COORD_W-1:0] hh;
        logic [RGB_W-1:0]   color;
    } s1_t;

    obj_t               shadow  [NUM_OBJ];
    obj_t               active  [NUM_OBJ];
    obj_t               cfg_obj;
    s1_t                s1_next [NUM_OBJ];
    s1_t                s1_q    [NUM_OBJ];
    logic [NUM_OBJ-1:0] hit_next;
    logic [NUM_OBJ-1:0] s2_hit;
    logic [RGB_W-1:0]   s2_color[NUM_OBJ];
    logic [RGB_W-1:0]   bg_q;
    logic               ready_q;
    logic               blank_s1;
    logic               blank_s2;
    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic [RGB_W-1:0]   sel_color;

    // Magnitude of the signed difference a-b; never wraps around the screen.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Inclusive-edge coverage test; squares are wide enough to never overflow.
    function automatic logic hit_test(input s1_t s);
        logic [SQ_W-1:0] d2;
        logic [SQ_W-1:0] r2;
        d2 = SQ_W'(s.adx) * SQ_W'(s.adx) + SQ_W'(s.ady) * SQ_W'(s.ady);
        r2 = SQ_W'(s.hw) * SQ_W'(s.hw);
        if (!s.en)
            return 1'b0;
        if (s.circle)
            return d2 <= r2;
        return (s.adx <= s.hw) && (s.ady <= s.hh);
    endfunction

    // Writes are refused on the commit cycle so they land in the next frame's shadow.
    assign cfg_ready = ready_q & ~frame_start;
    assign cfg_obj   = {cfg_en, cfg_circle, cfg_x, cfg_y, cfg_hw, cfg_hh, cfg_color};

    // Shadow/active descriptor tables, ready flag and background register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            ready_q <= 1'b0;
            bg_q    <= BG_COLOR;
        end else begin
            ready_q <= 1'b1;
            if (cfg_valid && cfg_ready && (32'(cfg_idx) < NUM_OBJ))
                shadow[cfg_idx] <= cfg_obj;
            if (frame_start)
                active <= shadow;
            if (bg_we)
                bg_q <= bg_color;
        end
    end

    // S1: distances against the active table; colour travels with the pixel.
    always_comb begin
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            s1_next[i].en     = active[i].en;
            s1_next[i].circle = active[i].circle;
            s1_next[i].adx    = abs_diff(DrawX, active[i].x);
            s1_next[i].ady    = abs_diff(DrawY, active[i].y);
            s1_next[i].hw     = active[i].hw;
            s1_next[i].hh     = active[i].hh;
            s1_next[i].color  = active[i].color;
        end
    end

    // S2: per-slot hit test.
    always_comb begin
        hit_next = '0;
        for (int i = 0; i < int'(NUM_OBJ); i++)
            hit_next[i] = hit_test(s1_q[i]);
    end

    // S3: lowest index wins; scanning downward leaves the lowest hit last.
    always_comb begin
        sel_hit   = 1'b0;
        sel_idx   = '0;
        sel_color = bg_q;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (s2_hit[i]) begin
                sel_hit   = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_color = s2_color[i];
            end
        end
    end

    // Pipeline registers and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                s1_q[i]     <= '0;
                s2_color[i] <= '0;
            end
            s2_hit    <= '0;
            blank_s1  <= 1'b0;
            blank_s2  <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            blank_out <= 1'b0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                s1_q[i]     <= s1_next[i];
                s2_color[i] <= s1_q[i].color;
            end
            s2_hit    <= hit_next;
            blank_s1  <= blank;
            blank_s2  <= blank_s1;
            Red       <= blank_s2 ? sel_color[RGB_W-1 -: COLOR_W]           : '0;
            Green     <= blank_s2 ? sel_color[RGB_W-COLOR_W-1 -: COLOR_W]   : '0;
            Blue      <= blank_s2 ? sel_color[COLOR_W-1:0]                  : '0;
            blank_out <= blank_s2;
            hit_valid <= sel_hit;
            hit_idx   <= sel_idx;
        end
    end
endmodule

// File: tb/tb_object_compositor.sv
// Bench for object_compositor: directed steps from the test plan plus a
// randomized phase, all checked against an integer-geometry reference model.
module tb_object_compositor;
    localparam int N  = 8;
    localparam int CW = 10;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [CW-1:0]   DrawX = '0, DrawY = '0;
    logic            blank = 1'b0, frame_start = 1'b0;
    logic            cfg_valid = 1'b0, cfg_en = 1'b0, cfg_circle = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_idx = '0;
    logic [CW-1:0]   cfg_x = '0, cfg_y = '0, cfg_hw = '0, cfg_hh = '0;
    logic [23:0]     cfg_color = '0, bg_color = '0;
    logic            bg_we = 1'b0;
    logic [7:0]      Red, Green, Blue;
    logic            blank_out, hit_valid;
    logic [2:0]      hit_idx;
    logic [28:0]     obs;

    object_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_circle(cfg_circle), .cfg_x(cfg_x),
        .cfg_y(cfg_y), .cfg_hw(cfg_hw), .cfg_hh(cfg_hh), .cfg_color(cfg_color),
        .bg_we(bg_we), .bg_color(bg_color), .Red(Red), .Green(Green), .Blue(Blue),
        .blank_out(blank_out), .hit_valid(hit_valid), .hit_idx(hit_idx)
    );

    always #5 Clk = ~Clk;

    assign obs = {blank_out, hit_valid, hit_idx, Red, Green, Blue};

    typedef struct {
        bit          en;
        bit          circ;
        int          x, y, hw, hh;
        logic [23:0] col;
    } mobj_t;

    typedef struct {
        int          step;
        bit          b;
        bit          hv;
        int          idx;
        logic [23:0] col;
    } exp_t;

    mobj_t       m_shadow [N];
    mobj_t       m_active [N];
    logic [23:0] m_bg;
    logic [23:0] bg_hist [8192];
    exp_t        q[$];
    int          step;
    bit          post_edge;
    string       tag;
    int          total;
    int          bad;

    function automatic logic [28:0] mk(bit b, bit hv, int idx, logic [23:0] rgb);
        return {b, hv, 3'(idx), b ? rgb : 24'h0};
    endfunction

    function automatic bit obj_hit(mobj_t o, int px, int py);
        int dx, dy;
        dx = px - o.x;
        dy = py - o.y;
        if (!o.en) return 1'b0;
        if (o.circ) return (dx * dx + dy * dy) <= (o.hw * o.hw);
        return (dx <= o.hw) && (-dx <= o.hw) && (dy <= o.hh) && (-dy <= o.hh);
    endfunction

    task automatic check(input string t, input logic [28:0] got, input logic [28:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '{default: 0};
            m_active[i] = '{default: 0};
        end
        m_bg = 24'h70707F;
        q.delete();
        // two empty pipeline stages precede the first driven pixel
        for (int i = 0; i < 2; i++) q.push_back('{0, 1'b0, 1'b0, 0, 24'h0});
        post_edge = 1'b0;
    endtask

    // One clock with the inputs currently driven: predict, advance, compare.
    task automatic cycle();
        exp_t e;
        bit   acc;
        #1;
        e = '{step, blank, 1'b0, 0, 24'h0};
        for (int i = 0; i < N; i++) begin
            if (!e.hv && obj_hit(m_active[i], int'(DrawX), int'(DrawY))) begin
                e.hv = 1'b1; e.idx = i; e.col = m_active[i].col;
            end
        end
        q.push_back(e);
        check({tag, "/cfg_ready"}, 29'(cfg_ready), 29'(post_edge && !frame_start));
        acc = cfg_valid && post_edge && !frame_start;
        if (acc) begin
            m_shadow[cfg_idx] = '{cfg_en, cfg_circle, int'(cfg_x), int'(cfg_y),
                                  int'(cfg_hw), int'(cfg_hh), cfg_color};
        end
        if (frame_start) m_active = m_shadow;
        if (bg_we) m_bg = bg_color;
        bg_hist[step % 8192] = m_bg;
        @(posedge Clk);
        #1;
        post_edge = 1'b1;
        step++;
        e = q.pop_front();
        check(tag, obs, mk(e.b, e.hv, e.idx, e.hv ? e.col : bg_hist[(e.step + 1) % 8192]));
        if (acc) cfg_valid = 1'b0;
        frame_start = 1'b0;
        bg_we = 1'b0;
    endtask

    task automatic set_cfg(int idx, bit en, bit circ, int x, int y, int hw, int hh,
                           logic [23:0] col);
        cfg_valid = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_circle = circ;
        cfg_x = CW'(x); cfg_y = CW'(y); cfg_hw = CW'(hw); cfg_hh = CW'(hh); cfg_color = col;
    endtask

    task automatic write_obj(int idx, bit en, bit circ, int x, int y, int hw, int hh,
                             logic [23:0] col);
        set_cfg(idx, en, circ, x, y, hw, hh, col);
        cycle();
    endtask

    task automatic commit();
        frame_start = 1'b1;
        cycle();
    endtask

    // Hold one pixel for the full latency and check against a literal value.
    task automatic probe(int x, int y, bit b, logic [28:0] want, string t);
        tag = t;
        DrawX = CW'(x); DrawY = CW'(y); blank = b;
        repeat (3) cycle();
        check(t, obs, want);
    endtask

    initial begin
        int k, px, py;
        total = 0; bad = 0; step = 0; tag = "reset";
        model_reset();

        // reset state
        repeat (2) @(posedge Clk);
        #1;
        check("reset_out", obs, 29'h0);
        check("reset_ready", 29'(cfg_ready), 29'h0);
        Reset_n = 1'b1;
        DrawX = 10'd100; DrawY = 10'd100; blank = 1'b1;

        tag = "empty";
        commit();
        probe(100, 100, 1'b1, mk(1, 0, 0, 24'h70707F), "empty_bg");
        probe(100, 100, 1'b0, 29'h0, "empty_blank");

        // rectangle in slot 2
        tag = "rect";
        write_obj(2, 1, 0, 50, 60, 4, 2, 24'hFF0000);
        commit();
        probe(46, 58, 1'b1, mk(1, 1, 2, 24'hFF0000), "rect_corner_lo");
        probe(54, 62, 1'b1, mk(1, 1, 2, 24'hFF0000), "rect_corner_hi");
        probe(45, 60, 1'b1, mk(1, 0, 0, 24'h70707F), "rect_miss_x");
        probe(50, 63, 1'b1, mk(1, 0, 0, 24'h70707F), "rect_miss_y");

        // circle in slot 1
        tag = "circle";
        write_obj(1, 1, 1, 100, 100, 5, 0, 24'h0000FF);
        commit();
        probe(103, 104, 1'b1, mk(1, 1, 1, 24'h0000FF), "circle_edge_hit");
        probe(104, 104, 1'b1, mk(1, 0, 0, 24'h70707F), "circle_miss");
        probe(103, 104, 1'b0, mk(0, 1, 1, 24'h0), "circle_blanked");

        // priority between overlapping slots 0 and 3
        tag = "prio";
        write_obj(0, 1, 0, 20, 20, 1, 1, 24'h00FF00);
        write_obj(3, 1, 0, 20, 20, 2, 2, 24'hFFFFFF);
        commit();
        probe(20, 20, 1'b1, mk(1, 1, 0, 24'h00FF00), "prio_slot0");
        write_obj(0, 0, 0, 20, 20, 1, 1, 24'h00FF00);
        commit();
        probe(20, 20, 1'b1, mk(1, 1, 3, 24'hFFFFFF), "prio_slot3");

        // clipping at the left edge, no wrap to the right edge
        tag = "clip";
        write_obj(4, 1, 0, 2, 10, 5, 0, 24'h123456);
        commit();
        probe(0, 10, 1'b1, mk(1, 1, 4, 24'h123456), "clip_hit");
        probe(1020, 10, 1'b1, mk(1, 0, 0, 24'h70707F), "clip_nowrap_1020");
        probe(1023, 10, 1'b1, mk(1, 0, 0, 24'h70707F), "clip_nowrap_1023");

        // write held across a frame_start cycle
        tag = "held";
        set_cfg(5, 1, 0, 300, 300, 3, 3, 24'hABCDEF);
        frame_start = 1'b1;
        #1;
        check("held_ready_low", 29'(cfg_ready), 29'h0);
        cycle();
        #1;
        check("held_ready_high", 29'(cfg_ready), 29'h1);
        cycle();
        check("held_accepted", 29'(cfg_valid), 29'h0);
        probe(300, 300, 1'b1, mk(1, 0, 0, 24'h70707F), "held_not_active");
        commit();
        probe(300, 300, 1'b1, mk(1, 1, 5, 24'hABCDEF), "held_active");

        // colour change with pixels in flight across the commit
        tag = "inflight";
        write_obj(5, 1, 0, 300, 300, 3, 3, 24'h00AA00);
        DrawX = 10'd301; DrawY = 10'd299;
        cycle(); cycle();
        frame_start = 1'b1;
        cycle(); cycle(); cycle();
        probe(300, 300, 1'b1, mk(1, 1, 5, 24'h00AA00), "inflight_new_color");

        // background register write
        bg_color = 24'h102030; bg_we = 1'b1;
        probe(600, 600, 1'b1, mk(1, 0, 0, 24'h102030), "bg_write");

        // randomized traffic
        tag = "random";
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 20) begin
                set_cfg($urandom_range(0, N - 1), $urandom_range(0, 9) != 0,
                        1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                        $urandom_range(0, 1023), $urandom_range(0, 40),
                        $urandom_range(0, 40), 24'($urandom));
            end
            frame_start = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) begin
                bg_we = 1'b1; bg_color = 24'($urandom);
            end
            k = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1) begin
                px = (m_active[k].x + $urandom_range(0, 90) - 45 + 1024) % 1024;
                py = (m_active[k].y + $urandom_range(0, 90) - 45 + 1024) % 1024;
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            DrawX = CW'(px); DrawY = CW'(py);
            blank = ($urandom_range(0, 9) != 0);
            cycle();
            cfg_valid = 1'b0;
        end

        // mid-line reset
        write_obj(6, 1, 0, 20, 20, 4, 4, 24'h445566);
        commit();
        DrawX = 10'd20; DrawY = 10'd20; blank = 1'b1;
        cycle(); cycle();
        Reset_n = 1'b0;
        #1;
        check("midreset_out", obs, 29'h0);
        check("midreset_ready", 29'(cfg_ready), 29'h0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tag = "after_reset";
        commit();
        probe(20, 20, 1'b1, mk(1, 0, 0, 24'h70707F), "after_reset_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
